// File: rtl/cache_controller_pkg.sv
// Shared definitions for the MEM-stage cache sequencer: state encoding,
// line/word geometry and the word-select helper used on line fills.
package cache_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_INV  = 2'd2,
    WR_SRAM = 2'd3
  } state_e;

  localparam int LINE_W       = 64;
  localparam int WORD_W       = 32;
  localparam int WORD_SEL_BIT = 2;

  // address[2]=1 picks the low word of the line, address[2]=0 the high word
  function automatic logic [WORD_W-1:0] select_word(input logic [LINE_W-1:0] line,
                                                    input logic              sel);
    return sel ? line[WORD_W-1:0] : line[LINE_W-1:WORD_W];
  endfunction

endpackage

// File: rtl/cache_controller_sat_counter.sv
// Saturating up-counter used for the hit/miss statistics; holds at all-ones.
module sat_counter
  import cache_controller_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_controller.sv
// MEM-stage sequencer: serves read hits from the cache, fills lines on read
// misses, and runs write-through (invalidate then SRAM write) for stores.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  input  logic [31:0]         address,
  input  logic [WORD_W-1:0]   write_data,
  input  logic                hit,
  input  logic [WORD_W-1:0]   cache_data,
  input  logic [LINE_W-1:0]   sram_read_data,
  input  logic                sram_ready,
  output logic                sram_r_en,
  output logic                sram_w_en,
  output logic [31:0]         sram_address,
  output logic [WORD_W-1:0]   sram_write_data,
  output logic                cache_u_en,
  output logic                cash_invalid,
  output logic [WORD_W-1:0]   read_data,
  output logic                ready,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
);

  state_e state_q;
  state_e state_d;
  logic   is_write;
  logic   is_read;
  logic   hit_inc;
  logic   miss_inc;

  // Stores win over loads when both enables are raised together
  assign is_write = mem_w_en;
  assign is_read  = mem_r_en & ~mem_w_en;

  assign sram_address    = address;
  assign sram_write_data = write_data;

  always_comb begin
    state_d      = state_q;
    sram_r_en    = 1'b0;
    sram_w_en    = 1'b0;
    cache_u_en   = 1'b0;
    cash_invalid = 1'b0;
    ready        = 1'b0;
    read_data    = cache_data;
    case (state_q)
      IDLE: begin
        if (is_write) begin
          state_d = WR_INV;
        end else if (is_read) begin
          if (hit) begin
            ready = 1'b1;
          end else begin
            state_d = RD_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      RD_MISS: begin
        sram_r_en = 1'b1;
        read_data = select_word(sram_read_data, address[WORD_SEL_BIT]);
        if (sram_ready) begin
          cache_u_en = 1'b1;
          ready      = 1'b1;
          state_d    = IDLE;
        end
      end
      WR_INV: begin
        cash_invalid = 1'b1;
        state_d      = WR_SRAM;
      end
      WR_SRAM: begin
        sram_w_en = 1'b1;
        if (sram_ready) begin
          ready   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
    // Reset overrides everything so the pipeline and SRAM see a quiet bus
    if (!rst) begin
      sram_r_en    = 1'b0;
      sram_w_en    = 1'b0;
      cache_u_en   = 1'b0;
      cash_invalid = 1'b0;
      ready        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Each miss is counted once, on the IDLE edge that launches the fill
  assign hit_inc  = (state_q == IDLE) & is_read & hit;
  assign miss_inc = (state_q == IDLE) & is_read & ~hit;

  sat_counter #(.W(CNT_W)) u_hit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a transaction-level model checks every
// cycle, and literal expectations pin the model on the key scenarios.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        memREn;
  logic        memWEn;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        hit;
  logic [31:0] cacheData;
  logic [63:0] sramReadData;
  logic        sramReady;

  logic        sramREn, sramWEn, cacheUEn, cashInvalid, ready;
  logic [31:0] sramAddress, sramWriteData, readData;
  logic [15:0] hitCount, missCount;

  logic        sramREnS, sramWEnS, cacheUEnS, cashInvalidS, readyS;
  logic [31:0] sramAddressS, sramWriteDataS, readDataS;
  logic [1:0]  hitCountS, missCountS;

  int compared   = 0;
  int mismatched = 0;

  cache_controller #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mem_r_en(memREn), .mem_w_en(memWEn),
    .address(address), .write_data(writeData), .hit(hit), .cache_data(cacheData),
    .sram_read_data(sramReadData), .sram_ready(sramReady),
    .sram_r_en(sramREn), .sram_w_en(sramWEn), .sram_address(sramAddress),
    .sram_write_data(sramWriteData), .cache_u_en(cacheUEn), .cash_invalid(cashInvalid),
    .read_data(readData), .ready(ready), .hit_count(hitCount), .miss_count(missCount)
  );

  cache_controller #(.CNT_W(2)) dutSmall (
    .clk(clk), .rst(rst), .mem_r_en(memREn), .mem_w_en(memWEn),
    .address(address), .write_data(writeData), .hit(hit), .cache_data(cacheData),
    .sram_read_data(sramReadData), .sram_ready(sramReady),
    .sram_r_en(sramREnS), .sram_w_en(sramWEnS), .sram_address(sramAddressS),
    .sram_write_data(sramWriteDataS), .cache_u_en(cacheUEnS), .cash_invalid(cashInvalidS),
    .read_data(readDataS), .ready(readyS), .hit_count(hitCountS), .miss_count(missCountS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic h, input logic [31:0] cd);
    memREn    = r;
    memWEn    = w;
    address   = a;
    writeData = wd;
    hit       = h;
    cacheData = cd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction model: what access is outstanding and how many cycles old it is
  localparam int K_NONE = 0, K_READ = 1, K_WRITE = 2;
  int mKind = K_NONE;
  int mAge  = 0;
  int mHits = 0, mMisses = 0, mHitsS = 0, mMissesS = 0;

  always @(negedge clk) begin
    logic        eReady, eRd, eWr, eFill, eInv, eRdValid;
    logic [31:0] eData;
    eReady = 0; eRd = 0; eWr = 0; eFill = 0; eInv = 0; eRdValid = 0; eData = '0;
    if (rst) begin
      if (mKind == K_NONE) begin
        if (memWEn) eReady = 0;
        else if (memREn) begin
          eReady = hit;
          eRdValid = hit;
          eData = cacheData;
        end else eReady = 1;
      end else if (mKind == K_READ) begin
        eRd = 1;
        if (sramReady) begin
          eReady = 1;
          eFill = 1;
          eRdValid = memREn;
          eData = address[2] ? sramReadData[31:0] : sramReadData[63:32];
        end
      end else begin
        if (mAge == 1) eInv = 1;
        else begin
          eWr = 1;
          eReady = sramReady;
        end
      end
    end
    checkOutput("ready", ready, eReady);
    checkOutput("sram_r_en", sramREn, eRd);
    checkOutput("sram_w_en", sramWEn, eWr);
    checkOutput("cache_u_en", cacheUEn, eFill);
    checkOutput("cash_invalid", cashInvalid, eInv);
    checkOutput("sram_address", sramAddress, address);
    checkOutput("sram_write_data", sramWriteData, writeData);
    checkOutput("hit_count", hitCount, mHits);
    checkOutput("miss_count", missCount, mMisses);
    checkOutput("small_ready", readyS, eReady);
    checkOutput("small_strobes", {sramREnS, sramWEnS, cacheUEnS, cashInvalidS},
                {eRd, eWr, eFill, eInv});
    checkOutput("small_hit_count", hitCountS, mHitsS);
    checkOutput("small_miss_count", missCountS, mMissesS);
    if (eRdValid) checkOutput("read_data", readData, eData);

    // Advance the model to what the coming rising edge should produce
    if (!rst) begin
      mKind = K_NONE; mHits = 0; mMisses = 0; mHitsS = 0; mMissesS = 0;
    end else if (mKind == K_NONE) begin
      if (memWEn) begin
        mKind = K_WRITE; mAge = 1;
      end else if (memREn && hit) begin
        if (mHits < 65535) mHits++;
        if (mHitsS < 3) mHitsS++;
      end else if (memREn) begin
        mKind = K_READ;
        if (mMisses < 65535) mMisses++;
        if (mMissesS < 3) mMissesS++;
      end
    end else if (mKind == K_READ) begin
      if (sramReady) mKind = K_NONE;
    end else begin
      if (mAge == 1) mAge = 2;
      else if (sramReady) mKind = K_NONE;
    end
  end

  initial begin
    int cnt, inv, cu, rdy;
    rst = 1'b0;
    sramReady = 1'b0;
    sramReadData = '0;
    applyStimulus(1, 0, 32'h100, 0, 0, 0);

    // Reset held with a load pending
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_ready", ready, 0);
      checkOutput("rst_sram_r_en", sramREn, 0);
      step();
    end
    rst = 1'b1;
    applyStimulus(0, 0, 32'h100, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_hit_count", hitCount, 0);
    checkOutput("rst_miss_count", missCount, 0);
    step();

    // Read hit
    applyStimulus(1, 0, 32'h100, 0, 1, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("hit_ready", ready, 1);
    checkOutput("hit_read_data", readData, 32'hDEADBEEF);
    checkOutput("hit_sram_r_en", sramREn, 0);
    step();
    applyStimulus(0, 0, 32'h100, 0, 0, 0);
    sramReady = 1'b1;
    @(negedge clk);
    checkOutput("hit_count_one", hitCount, 1);
    checkOutput("idle_sram_ready_ignored", cacheUEn, 0);
    step();
    sramReady = 1'b0;

    // Read miss, address[2]=1
    applyStimulus(1, 0, 32'h204, 0, 0, 32'h0BAD0BAD);
    @(negedge clk);
    checkOutput("miss_idle_ready", ready, 0);
    step();
    cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) begin
        sramReady = 1'b1;
        sramReadData = 64'h11112222_33334444;
      end
      @(negedge clk);
      if (sramREn) cnt++;
      if (i == 6) begin
        checkOutput("miss_fill", cacheUEn, 1);
        checkOutput("miss_ready", ready, 1);
        checkOutput("miss_read_data", readData, 32'h33334444);
      end
      step();
    end
    sramReady = 1'b0;
    applyStimulus(0, 0, 32'h204, 0, 0, 0);
    checkOutput("miss_r_en_cycles", cnt, 6);
    @(negedge clk);
    checkOutput("miss_r_en_dropped", sramREn, 0);
    checkOutput("miss_count_one", missCount, 1);
    step();

    // Write with a stray sram_ready during the invalidate cycle
    applyStimulus(0, 1, 32'h400, 32'h5, 0, 0);
    @(negedge clk);
    checkOutput("wr_idle_ready", ready, 0);
    step();
    inv = 0; cu = 0; rdy = 0;
    for (int i = 1; i <= 5; i++) begin
      sramReady = (i == 1) || (i == 5);
      @(negedge clk);
      if (cashInvalid) inv++;
      if (cacheUEn) cu++;
      if (ready) rdy++;
      if (i >= 2) checkOutput("wr_sram_w_en_held", sramWEn, 1);
      step();
    end
    sramReady = 1'b0;
    applyStimulus(0, 0, 32'h400, 32'h5, 0, 0);
    checkOutput("wr_inv_pulses", inv, 1);
    checkOutput("wr_fill_cycles", cu, 0);
    checkOutput("wr_ready_cycles", rdy, 1);

    // Simultaneous load and store: store wins
    applyStimulus(1, 1, 32'h208, 32'h77, 0, 0);
    @(negedge clk);
    step();
    @(negedge clk);
    checkOutput("both_inv", cashInvalid, 1);
    step();
    sramReady = 1'b1;
    @(negedge clk);
    checkOutput("both_w_en", sramWEn, 1);
    checkOutput("both_ready", ready, 1);
    step();
    sramReady = 1'b0;
    applyStimulus(0, 0, 32'h208, 0, 0, 0);
    @(negedge clk);
    checkOutput("both_miss_unchanged", missCount, 1);
    step();

    // Load dropped mid-miss still finishes the fill
    applyStimulus(1, 0, 32'h300, 0, 0, 0);
    step();
    applyStimulus(0, 0, 32'h300, 0, 0, 0);
    @(negedge clk);
    checkOutput("drop_r_en_kept", sramREn, 1);
    step();
    sramReady = 1'b1;
    sramReadData = 64'hAAAA5555_01234567;
    @(negedge clk);
    checkOutput("drop_fill", cacheUEn, 1);
    step();
    sramReady = 1'b0;
    @(negedge clk);
    checkOutput("drop_idle", sramREn, 0);
    checkOutput("drop_miss_count", missCount, 2);
    step();

    // Reset two cycles into a miss
    applyStimulus(1, 0, 32'h10C, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_r_en", sramREn, 0);
    step();
    rst = 1'b1;
    applyStimulus(0, 0, 32'h10C, 0, 0, 0);
    @(negedge clk);
    checkOutput("midrst_idle_r_en", sramREn, 0);
    checkOutput("midrst_idle_ready", ready, 1);
    checkOutput("midrst_miss_clear", missCount, 0);
    step();

    // Five hits: narrow counter saturates at 3
    applyStimulus(1, 0, 32'h110, 0, 1, 32'hCAFEF00D);
    repeat (5) step();
    applyStimulus(0, 0, 32'h110, 0, 0, 0);
    @(negedge clk);
    checkOutput("sat_small_hits", hitCountS, 3);
    checkOutput("sat_wide_hits", hitCount, 5);
    step();
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- MEM-stage sequencer between the pipeline, the 2-way 64-set data cache and the SRAM controller.
- Read hits are served from the cache in zero wait cycles.
- Read misses fetch a 64-bit line from SRAM, fill the cache and forward the requested word.
- Writes are write-through with no allocate: invalidate the cached line, then write SRAM.
- Drives the pipeline stall via `ready` and keeps saturating hit/miss statistics.

Parameters:
- CNT_W, 16, width of the hit and miss statistic counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- mem_r_en  in  1  pipeline load request; level, held until `ready`.
- mem_w_en  in  1  pipeline store request; level, held until `ready`.
- address  in  32  byte address of the request; stable while the request is held.
- write_data  in  32  store data.
- hit  in  1  cache hit for `address` (combinational from the cache).
- cache_data  in  32  cache read word for `address`.
- sram_read_data  in  64  SRAM line; valid in the cycle `sram_ready`=1.
- sram_ready  in  1  one-cycle pulse: SRAM access complete.
- sram_r_en  out  1  SRAM read request; level.
- sram_w_en  out  1  SRAM write request; level.
- sram_address  out  32  equals `address`.
- sram_write_data  out  32  equals `write_data`.
- cache_u_en  out  1  cache line-fill strobe; drives the cache mem_u_en.
- cash_invalid  out  1  cache invalidate strobe for `address`.
- read_data  out  32  load result; valid when `ready`=1 and `mem_r_en`=1.
- ready  out  1  1 = request complete or no request; pipeline freeze = ~ready.
- hit_count  out  CNT_W  saturating count of read hits.
- miss_count  out  CNT_W  saturating count of read misses.

Behaviour:
- Reset (rst=0 at an edge): state becomes IDLE and both counters clear.
- While rst=0, outputs are forced: sram_r_en, sram_w_en, cache_u_en, cash_invalid and ready are all 0.
- Reset mid-access: abandon the access and return to IDLE. The SRAM controller is reset by the same rst.
- States: IDLE, RD_MISS, WR_INV, WR_SRAM.
- Request decode: mem_w_en=1 means write, regardless of mem_r_en (write has priority). mem_r_en=1 alone means read.
- IDLE, no request: ready=1 and no strobes.
- IDLE, read with hit=1:
  - ready=1 combinationally in the same cycle; read_data=cache_data.
  - hit_count increments at the edge; state stays IDLE.
- IDLE, read with hit=0:
  - ready=0; go to RD_MISS.
  - miss_count increments at this edge only, once per miss.
- RD_MISS:
  - sram_r_en=1 each cycle until sram_ready.
  - In the sram_ready cycle: cache_u_en=1 for exactly that cycle and ready=1.
  - read_data = address[2] ? sram_read_data[31:0] : sram_read_data[63:32].
  - Next state is IDLE; sram_r_en drops the following cycle.
- IDLE, write: ready=0; go to WR_INV.
- WR_INV: cash_invalid=1 for exactly one cycle (cache set-select is still valid because address is held); go to WR_SRAM.
- WR_SRAM:
  - sram_w_en=1 until sram_ready.
  - In the sram_ready cycle: ready=1; next state is IDLE.
- Latency: read hit 0 extra cycles; read miss 1 + SRAM latency; write 2 + SRAM latency.
- sram_ready while in IDLE or WR_INV is ignored.
- cache_u_en and cash_invalid are never 1 in the same cycle.
- Counters saturate at 2^CNT_W-1; no wrap-around.
- Request dropped mid-access (illegal): complete the SRAM access anyway, then return to IDLE.
- All outputs are Moore-style from state, except:
  - ready and read_data in IDLE (combinational from hit);
  - the sram_ready-qualified outputs in RD_MISS/WR_SRAM.

Decomposition:
- Shared package holds:
  - state encoding (2-bit: IDLE=0, RD_MISS=1, WR_INV=2, WR_SRAM=3);
  - LINE_W=64 and WORD_W=32;
  - word-select bit index 2.
- One natural sub-module, sat_counter (parameter W; inputs clk, rst, inc; output count). Instantiated twice.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with mem_r_en=1 → ready=0, sram_r_en=0; counters 0 after rst rises.
2. Read hit: mem_r_en=1, hit=1, cache_data=32'hDEADBEEF → same-cycle ready=1, read_data=DEADBEEF; hit_count=1; sram_r_en never asserted.
3. Read miss, address[2]=1: sram_ready pulsed 6 cycles after entry, sram_read_data=64'h11112222_33334444 → sram_r_en high 6 cycles; in the ready cycle cache_u_en=1 and read_data=33334444; miss_count=1.
4. Write: mem_w_en=1, address=32'h400, write_data=5 → cash_invalid pulses exactly 1 cycle, then sram_w_en is held; ready=1 only in the sram_ready cycle; cache_u_en stays 0.
5. Simultaneous mem_r_en=mem_w_en=1 → write sequence taken (cash_invalid pulse, then sram_w_en); miss_count unchanged.
6. rst=0 during RD_MISS, 2 cycles in → next cycle sram_r_en=0, state IDLE. With CNT_W=2, 5 hits → hit_count=3 (saturated).
